// File: rtl/hc194_seq.sv
// hc194_seq: command sequencer that drives a 4-bit universal shift register through N timed mode steps.
// Define HC194_SEQ_SOUT_EN to register the bit shifted out on every shift step (SOUT/SOUT_VLD).
`timescale 1ns/1ps
module hc194_seq (
  input  logic       CP,
  input  logic       MR,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [2:0] CMD_CNT,
  input  logic [3:0] CMD_DATA,
  input  logic       CMD_ROT,
  input  logic       CMD_FILL,
  input  logic [3:0] Q,
  output logic       S0,
  output logic       S1,
  output logic [3:0] D,
  output logic       DSR,
  output logic       DSL,
  output logic       BUSY,
  output logic       DONE,
  output logic       SOUT,
  output logic       SOUT_VLD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] op;
  logic       rot;
  logic       fill;

  assign CMD_READY = (state == IDLE) && !MR;
  assign BUSY      = (state != IDLE);

  // Serial inputs follow Q live so a rotate feeds back the current end bit each step.
  assign DSL = (state == IDLE) ? 1'b0 : (rot ? Q[3] : fill);
  assign DSR = (state == IDLE) ? 1'b0 : (rot ? Q[0] : fill);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op    <= 2'b00;
      rot   <= 1'b0;
      fill  <= 1'b0;
      S0    <= 1'b0;
      S1    <= 1'b0;
      D     <= 4'd0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            op    <= CMD_OP;
            rot   <= CMD_ROT;
            fill  <= CMD_FILL;
            D     <= CMD_DATA;
            S1    <= CMD_OP[1];
            S0    <= CMD_OP[0];
            state <= RUN;
            if (CMD_OP == 2'b11)
              cnt <= 4'd1;
            else if (CMD_CNT == 3'd0)
              cnt <= 4'd8;
            else
              cnt <= {1'b0, CMD_CNT};
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          // Last step: the register samples the mode one final time on this edge.
          if (cnt == 4'd1) begin
            S1    <= 1'b0;
            S0    <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HC194_SEQ_SOUT_EN
  // Capture the pre-shift end bit that leaves the register on each shift edge.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      SOUT     <= 1'b0;
      SOUT_VLD <= 1'b0;
    end else if (state == RUN && op == 2'b10) begin
      SOUT     <= Q[3];
      SOUT_VLD <= 1'b1;
    end else if (state == RUN && op == 2'b01) begin
      SOUT     <= Q[0];
      SOUT_VLD <= 1'b1;
    end else begin
      SOUT_VLD <= 1'b0;
    end
  end
`else
  assign SOUT     = 1'b0;
  assign SOUT_VLD = 1'b0;
`endif

endmodule

// File: tb/tb_hc194_seq.sv
// Bench for hc194_seq: a behavioural shift-register model closes the Q loop, a transaction-level
// model predicts each command's timeline and result; honours HC194_SEQ_SOUT_EN like the design.
`timescale 1ns/1ps
module tb_hc194_seq;

  logic       CP, MR, CMD_VALID, CMD_READY, CMD_ROT, CMD_FILL;
  logic [1:0] CMD_OP;
  logic [2:0] CMD_CNT;
  logic [3:0] CMD_DATA, Q, D;
  logic       S0, S1, DSR, DSL, BUSY, DONE, SOUT, SOUT_VLD;

  int nvec = 0;
  int nerr = 0;

  hc194_seq dut (
    .CP(CP), .MR(MR), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_CNT(CMD_CNT), .CMD_DATA(CMD_DATA),
    .CMD_ROT(CMD_ROT), .CMD_FILL(CMD_FILL), .Q(Q),
    .S0(S0), .S1(S1), .D(D), .DSR(DSR), .DSL(DSL),
    .BUSY(BUSY), .DONE(DONE), .SOUT(SOUT), .SOUT_VLD(SOUT_VLD)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  // External shift register: left moves toward Q3 (DSL into Q0), right toward Q0 (DSR into Q3).
  logic [3:0] q_reg, q_pre;
  initial q_reg = 4'b0000;
  always @(posedge CP) begin
    q_pre = q_reg;
    case ({S1, S0})
      2'b01:   q_reg <= {DSR, q_reg[3:1]};
      2'b10:   q_reg <= {q_reg[2:0], DSL};
      2'b11:   q_reg <= D;
      default: ;
    endcase
  end
  assign Q = q_reg;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Whole-command prediction: final Q and the sequence of bits leaving the register.
  task automatic predict(input logic [3:0] q0, input logic [1:0] op, input int n, input logic rot,
                         input logic fill, input logic [3:0] data,
                         output logic [3:0] res, output logic [7:0] sb);
    int v, b;
    v  = int'(q0);
    sb = '0;
    for (int i = 0; i < n; i++) begin
      if (op == 2'b10) begin
        b = v / 8;
        sb[i] = b[0];
        v = (v * 2) % 16 + (rot ? b : int'(fill));
      end else if (op == 2'b01) begin
        b = v % 2;
        sb[i] = b[0];
        v = v / 2 + 8 * (rot ? b : int'(fill));
      end
    end
    if (op == 2'b11) v = int'(data);
    res = 4'(v);
  endtask

  // Timeline model: k = cycles since the accept edge (0 = idle); cycles 1..N run, N+1 is FIN.
  int         m_k = 0;
  int         m_n = 0;
  logic [1:0] m_op = 2'b00;
  logic       m_rot = 1'b0, m_fill = 1'b0, m_sout = 1'b0;
  logic [3:0] m_d = 4'd0, m_res = 4'd0;
  logic [7:0] m_sbits = 8'd0;

  always @(negedge CP) begin
    logic exp_run, exp_fin, exp_vld;
    if (MR) begin
      m_k = 0; m_d = 4'd0; m_sout = 1'b0;
    end else if (m_k == 0) begin
      if (CMD_VALID) begin
        m_op = CMD_OP; m_rot = CMD_ROT; m_fill = CMD_FILL; m_d = CMD_DATA;
        m_n = (CMD_OP == 2'b11) ? 1 : ((CMD_CNT == 3'd0) ? 8 : int'(CMD_CNT));
        predict(q_pre, CMD_OP, m_n, CMD_ROT, CMD_FILL, CMD_DATA, m_res, m_sbits);
        m_k = 1;
      end
    end else if (m_k == m_n + 1) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    exp_vld = 1'b0;
`ifdef HC194_SEQ_SOUT_EN
    if (!MR && m_k >= 2 && (m_op == 2'b01 || m_op == 2'b10)) begin
      exp_vld = 1'b1;
      m_sout  = m_sbits[m_k - 2];
    end
`endif
    exp_run = !MR && m_k >= 1 && m_k <= m_n;
    exp_fin = !MR && m_k >= 1 && m_k == m_n + 1;
    chk("ready", 8'(CMD_READY), 8'(!MR && m_k == 0));
    chk("busy", 8'(BUSY), 8'(m_k != 0));
    chk("done", 8'(DONE), 8'(exp_fin));
    chk("s1s0", 8'({S1, S0}), 8'(exp_run ? m_op : 2'b00));
    chk("d", 8'(D), 8'(m_d));
    chk("dsl", 8'(DSL), 8'(m_k == 0 ? 1'b0 : (m_rot ? Q[3] : m_fill)));
    chk("dsr", 8'(DSR), 8'(m_k == 0 ? 1'b0 : (m_rot ? Q[0] : m_fill)));
    chk("sout", 8'(SOUT), 8'(m_sout));
    chk("sout_vld", 8'(SOUT_VLD), 8'(exp_vld));
    if (exp_fin) chk("q_final", 8'(Q), 8'(m_res));
  end

  // Entered and left at negedge+2; leaves CMD_VALID high for the caller to drop.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                       input logic rot, input logic fill);
    logic acc;
    int   t;
    CMD_VALID = 1'b1; CMD_OP = op; CMD_CNT = cnt; CMD_DATA = data; CMD_ROT = rot; CMD_FILL = fill;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 60) begin
      #2 acc = CMD_READY;
      @(negedge CP); #2;
      t++;
    end
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL issue: no accept within %0d cycles, ready=%0b required 1", t, CMD_READY);
    end
  endtask

  task automatic wait_done(output logic [3:0] qf, output int sc, output logic [7:0] sb, output int nv);
    int t;
    sc = 0; sb = '0; nv = 0; t = 0;
    while (t < 20) begin
      if ({S1, S0} != 2'b00) sc++;
      if (SOUT_VLD && nv < 8) begin sb[nv] = SOUT; nv++; end
      if (DONE) break;
      @(negedge CP); #1;
      t++;
    end
    qf = Q;
    chk("wait_done", 8'(DONE), 8'd1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                        input logic rot, input logic fill,
                        output logic [3:0] qf, output int sc, output logic [7:0] sb, output int nv);
    issue(op, cnt, data, rot, fill);
    CMD_VALID = 1'b0;
    wait_done(qf, sc, sb, nv);
    @(negedge CP); #2;
    chk("done_one_pulse", 8'(DONE), 8'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] qf;
    logic [7:0] sb;
    int         sc, nv, a0, a1;
    MR = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_CNT = 3'd0; CMD_DATA = 4'd0;
    CMD_ROT = 1'b0; CMD_FILL = 1'b0;
    @(negedge CP); #2;
    chk("rst_ready", 8'(CMD_READY), 8'd0);
    chk("rst_d", 8'(D), 8'd0);
    @(negedge CP); #2;
    MR = 1'b0;
    @(negedge CP); #2;

    do_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, qf, sc, sb, nv);
    chk("load_q", 8'(qf), 8'b1011);
    chk("load_mode_cycles", 8'(sc), 8'd1);

    do_cmd(2'b10, 3'd1, 4'd0, 1'b1, 1'b0, qf, sc, sb, nv);
    chk("rotl1_q", 8'(qf), 8'b0111);

    do_cmd(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0, qf, sc, sb, nv);
    do_cmd(2'b10, 3'd0, 4'd0, 1'b1, 1'b0, qf, sc, sb, nv);
    chk("rotl8_q", 8'(qf), 8'b1011);
    chk("rotl8_mode_cycles", 8'(sc), 8'd8);

    do_cmd(2'b01, 3'd3, 4'd0, 1'b0, 1'b0, qf, sc, sb, nv);
    chk("fillr3_q", 8'(qf), 8'b0001);
    chk("fillr3_mode_cycles", 8'(sc), 8'd3);
`ifdef HC194_SEQ_SOUT_EN
    chk("fillr3_sout_pulses", 8'(nv), 8'd3);
    chk("fillr3_sout_bits", 8'(sb[2:0]), 8'b011);
`else
    chk("fillr3_sout_pulses", 8'(nv), 8'd0);
`endif

    do_cmd(2'b00, 3'd2, 4'd6, 1'b0, 1'b1, qf, sc, sb, nv);
    chk("hold_q", 8'(qf), 8'b0001);
    chk("hold_mode_cycles", 8'(sc), 8'd0);

    // Back-to-back: valid held high, N=3, so accepts land 5 cycles apart.
    CMD_VALID = 1'b1; CMD_OP = 2'b10; CMD_CNT = 3'd3; CMD_ROT = 1'b1; CMD_FILL = 1'b0; CMD_DATA = 4'h5;
    a0 = -1; a1 = -1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (CMD_READY) begin
        if (a0 < 0) a0 = i;
        else if (a1 < 0) a1 = i;
      end
      @(negedge CP); #2;
    end
    CMD_VALID = 1'b0;
    chk("hs_first_accept", 8'(a0), 8'd0);
    chk("hs_spacing", 8'(a1 - a0), 8'd5);
    repeat (8) begin @(negedge CP); #2; end

    // Reset two cycles into a 5-step shift.
    issue(2'b01, 3'd5, 4'd0, 1'b1, 1'b0);
    CMD_VALID = 1'b0;
    @(negedge CP); #2;
    MR = 1'b1;
    #1;
    chk("rst_run_s1s0", 8'({S1, S0}), 8'd0);
    chk("rst_run_done", 8'(DONE), 8'd0);
    chk("rst_run_busy", 8'(BUSY), 8'd0);
    chk("rst_run_ready", 8'(CMD_READY), 8'd0);
    @(negedge CP); #2;
    MR = 1'b0;
    CMD_VALID = 1'b1; CMD_OP = 2'b11; CMD_DATA = 4'b1011; CMD_CNT = 3'd0;
    #1;
    chk("rst_release_ready", 8'(CMD_READY), 8'd1);
    @(posedge CP); #1;
    chk("rst_first_edge_accept", 8'(BUSY), 8'd1);
    @(negedge CP); #2;
    CMD_VALID = 1'b0;
    repeat (4) begin @(negedge CP); #2; end

    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      CMD_VALID = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 10)) begin @(negedge CP); #2; end
      if ($urandom_range(0, 9) == 0) begin
        MR = 1'b1;
        @(negedge CP); #2;
        MR = 1'b0;
      end
    end
    CMD_VALID = 1'b0;
    repeat (12) begin @(negedge CP); #2; end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
